// File: rtl/instr_word_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_word_encoder_if
// Purpose  : Request handshake plus instruction-memory write bus for the encoder
// Revision : 1.0
// ============================================================================
interface instr_word_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output op_valid, op_kind, rs, rt, rd, imm,
    input  op_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  op_valid, op_kind, rs, rt, rd, imm,
    output op_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_word_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_word_encoder
// Purpose  : Encodes R-type/LW/SW/BEQ(/ADDI) requests into MIPS words and
//            streams them into instruction memory. Optional macro: ENC_ADDI_EN.
// Revision : 1.0
// ============================================================================
module instr_word_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  input  wire logic              flush,
  instr_word_encoder_if.slave    bus,
  output logic                   err_illegal,
  output logic [ADDR_W:0]        count,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef ENC_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              session_start;

  logic              op_ready;
  logic              accept;
  logic              enc_legal;
  logic              enc_is_r;
  logic [5:0]        enc_funct;
  logic [5:0]        enc_opcode;
  logic [31:0]       enc_word;

  logic [ADDR_W:0]   accepted;
  logic [ADDR_W-1:0] ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              err_q;
  logic [ADDR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // flush outranks start only while a session is running
  always_comb begin
    state_nx      = state;
    session_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx      = RUN;
          session_start = 1'b1;
        end
      end
      RUN: begin
        if (flush || (accepted == DEPTH_C)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nx      = RUN;
          session_start = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign op_ready = (state == RUN) && !flush && (accepted < DEPTH_C);
  assign accept   = bus.op_valid && op_ready;

  always_comb begin
    enc_legal  = 1'b1;
    enc_is_r   = 1'b0;
    enc_funct  = 6'd0;
    enc_opcode = 6'd0;
    case (bus.op_kind)
      4'd0: begin enc_is_r = 1'b1; enc_funct = FN_ADD; end
      4'd1: begin enc_is_r = 1'b1; enc_funct = FN_SUB; end
      4'd2: begin enc_is_r = 1'b1; enc_funct = FN_AND; end
      4'd3: begin enc_is_r = 1'b1; enc_funct = FN_OR;  end
      4'd4: begin enc_is_r = 1'b1; enc_funct = FN_XOR; end
      4'd5: begin enc_is_r = 1'b1; enc_funct = FN_NOR; end
      4'd6: enc_opcode = OP_LW;
      4'd7: enc_opcode = OP_SW;
      4'd8: enc_opcode = OP_BEQ;
`ifdef ENC_ADDI_EN
      4'd9: enc_opcode = OP_ADDI;
`endif
      default: enc_legal = 1'b0;
    endcase
    if (enc_is_r) begin
      enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, enc_funct};
    end else begin
      enc_word = {enc_opcode, bus.rs, bus.rt, bus.imm};
    end
  end

  // imem_addr is latched from ptr at accept so it holds after the write
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= BASE_C;
      wr_data  <= 32'd0;
      err_q    <= 1'b0;
      ptr      <= BASE_C;
      accepted <= '0;
      count_q  <= '0;
    end else begin
      wr_en <= accept && enc_legal;
      err_q <= accept && !enc_legal;
      if (accept && enc_legal) begin
        wr_addr  <= ptr;
        wr_data  <= enc_word;
        ptr      <= ptr + PTR_ONE;
        accepted <= accepted + CNT_ONE;
      end
      if (session_start) begin
        ptr      <= BASE_C;
        accepted <= '0;
        count_q  <= '0;
      end else if (wr_en) begin
        count_q  <= count_q + CNT_ONE;
      end
    end
  end

  assign bus.op_ready   = op_ready;
  assign bus.imem_we    = wr_en;
  assign bus.imem_addr  = wr_addr;
  assign bus.imem_wdata = wr_data;
  assign err_illegal    = err_q;
  assign count          = count_q;
  assign busy           = (state == RUN);
  assign done           = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_word_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_word_encoder
// Purpose  : Directed plus randomized checks of instr_word_encoder (DEPTH=4)
// Revision : 1.0
// ============================================================================
module tb_instr_word_encoder;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic clk = 1'b0;
  logic reset, start, flush;
  logic err_illegal, busy, done;
  logic [ADDR_W:0] count;

  instr_word_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_word_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .bus(bus),
    .err_illegal(err_illegal), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: expected writes and session bookkeeping
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_word[$];
  bit m_started = 0;
  bit m_flushed = 0;
  int m_acc = 0;
  int m_ptr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_kind(input int k);
`ifdef ENC_ADDI_EN
    return k <= 9;
`else
    return k <= 8;
`endif
  endfunction

  function automatic logic [31:0] ref_word(input int k, input int a, input int b, input int c, input int im);
    int unsigned fn[6] = '{32, 34, 36, 37, 38, 39};
    int unsigned oc[4] = '{35, 43, 4, 8};
    int unsigned w;
    if (k < 6) w = 32'(a) * 32'd2097152 + 32'(b) * 32'd65536 + 32'(c) * 32'd2048 + fn[k];
    else       w = oc[k-6] * 32'd67108864 + 32'(a) * 32'd2097152 + 32'(b) * 32'd65536 + 32'(im);
    return w;
  endfunction

  function automatic bit m_done();
    return m_started && (m_flushed || m_acc == DEPTH);
  endfunction

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        check("spurious_write", bus.imem_we, 1'b0);
      end else begin
        check("wr_addr", bus.imem_addr, exp_addr.pop_front());
        check("wr_data", bus.imem_wdata, exp_word.pop_front());
      end
    end
  end

  task automatic send(input int k, input int a, input int b, input int c, input int im);
    bit rdy, lg;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_kind  = 4'(k);
    bus.rs = 5'(a); bus.rt = 5'(b); bus.rd = 5'(c); bus.imm = 16'(im);
    rdy = m_started && !m_done() && (m_acc < DEPTH);
    lg  = legal_kind(k);
    #1 check("op_ready", bus.op_ready, rdy);
    if (rdy && lg) begin
      exp_addr.push_back(ADDR_W'(BASE + m_ptr));
      exp_word.push_back(ref_word(k, a, b, c, im));
      m_ptr++;
      m_acc++;
    end
    @(posedge clk); #1;
    check("err_illegal", err_illegal, rdy && !lg);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    idle(3);
    check("count", count, m_acc);
    check("done", done, m_done());
    check("busy", busy, m_started && !m_done());
    check("writes_drained", exp_addr.size(), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.op_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!m_started || m_done()) begin
      m_started = 1; m_flushed = 0; m_acc = 0; m_ptr = 0;
    end
    check("start_busy", busy, 1'b1);
    check("start_count", count, m_acc);
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_kind  = 4'd0;
    flush = 1'b1;
    #1 check("flush_blocks_ready", bus.op_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.op_valid = 1'b0;
    if (m_started) m_flushed = 1;
    check("flush_done", done, m_done());
  endtask

  task automatic check_reset_values();
    check("rst_op_ready", bus.op_ready, 1'b0);
    check("rst_imem_we", bus.imem_we, 1'b0);
    check("rst_imem_addr", bus.imem_addr, ADDR_W'(BASE));
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_err", err_illegal, 1'b0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    bus.op_valid = 1'b0; bus.op_kind = 4'd0;
    bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0; bus.imm = 16'd0;
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk) reset = 1'b0;

    // single ADD
    do_start();
    send(0, 1, 2, 3, 0);
    settle();
    check("add_word_hold", bus.imem_wdata, 32'h0022_1820);
    check("add_addr_hold", bus.imem_addr, 8'd0);

    // back-to-back I-type
    do_flush(); do_start();
    send(6, 4, 5, 0, 16'h0010);
    send(7, 4, 5, 0, 16'hFFFC);
    send(8, 1, 2, 0, 3);
    settle();
    check("beq_word_hold", bus.imem_wdata, 32'h1022_0003);
    check("beq_addr_hold", bus.imem_addr, 8'd2);

    // illegal between two ADDs
    do_flush(); do_start();
    send(0, 1, 1, 1, 0);
    send(12, 3, 3, 3, 0);
    send(0, 2, 2, 2, 0);
    settle();
    check("illegal_addr_hold", bus.imem_addr, 8'd1);

    // ADDI (legal only with the optional encoder)
    do_flush(); do_start();
    send(9, 0, 8, 0, 5);
    settle();
`ifdef ENC_ADDI_EN
    check("addi_word", bus.imem_wdata, 32'h2008_0005);
`endif

    // depth limit: five requests, four accepted
    do_flush(); do_start();
    for (int i = 0; i < 5; i++) send(i, i + 1, i + 2, i + 3, 0);
    settle();
    check("depth_addr_hold", bus.imem_addr, 8'd3);

    // start while running is ignored
    do_start();
    send(1, 7, 8, 9, 0);
    do_start();
    settle();

    // flush while a write is pending
    do_flush(); do_start();
    send(3, 10, 11, 12, 0);
    do_flush();
    settle();

    // randomized sessions
    for (int s = 0; s < 10; s++) begin
      int n;
      do_start();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int k;
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        send(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      settle();
      if (!m_done()) begin
        do_flush();
        settle();
      end
    end

    // reset mid-session drops the pending accept
    do_start();
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_kind = 4'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    m_started = 0; m_flushed = 0; m_acc = 0; m_ptr = 0;
    check_reset_values();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_we", bus.imem_we, 1'b0);
    check("post_reset_idle", busy, 1'b0);
    check("final_queue_empty", exp_addr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/instr_word_encoder.md
# instr_word_encoder

Encodes symbolic instruction requests into 32-bit MIPS machine words and writes them sequentially into the instruction memory write port. It is the encode side of the single-cycle CPU's instruction-decode path: it produces words for the R-type, LW, SW, BEQ and ADDI subset that the control unit decodes. A valid/ready request interface feeds a one-stage registered write pipeline, and a load FSM tracks progress. The block sits between the testbench or boot loader and the instruction memory.

## Interface
Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 256, maximum number of words per load session; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- BASE_ADDR, 0, word address of the first write.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, opens a load session from IDLE or DONE.
- flush, input, 1, ends the current session early.
- op_valid, input, 1, request valid.
- op_ready, output, 1, request accepted when op_valid && op_ready.
- op_kind, input, 4, operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 LW, 7 SW, 8 BEQ, 9 ADDI, 10–15 illegal.
- rs, rt, rd, input, 5 each, register fields.
- imm, input, 16, immediate / offset field.
- imem_we, output, 1, write strobe.
- imem_addr, output, ADDR_W, write word address.
- imem_wdata, output, 32, encoded instruction word.
- err_illegal, output, 1, one-cycle pulse for an illegal kind.
- count, output, ADDR_W+1, legal words written in the current session.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → DONE when the DEPTH-th legal accept has been written, or on flush.
  - DONE → RUN on start.
  - start while in RUN is ignored.
- Session start: entering RUN clears count and sets the write pointer to BASE_ADDR.
- op_ready = (state==RUN) && !flush && (accepted < DEPTH).
  - accepted counts legal accepts in the session.
  - This is the only combinational input-to-output path.
- R-type encoding: {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - funct per kind: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
- I-type encoding: {opcode, rs, rt, imm}.
  - Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
- Legal accept:
  - The encoded word is registered.
  - The next cycle asserts imem_we=1 with the current pointer on imem_addr.
  - The pointer and count increment after that write.
- Illegal accept:
  - The request is consumed; no write occurs.
  - err_illegal pulses on the next cycle.
  - The pointer, count and accepted counter are unchanged.
- Address arithmetic wraps modulo 2^ADDR_W; with BASE_ADDR+DEPTH > 2^ADDR_W, writes continue from 0.
- imem_addr and imem_wdata hold their last values when imem_we=0.

## Timing
- Reset values: op_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, err_illegal=0, count=0, busy=0, done=0; state IDLE.
- Latency: accept at edge T gives imem_we at cycle T+1. count reflects the write from T+2.
- Throughput: one word per cycle with op_valid held high.
- Last word: the DEPTH-th legal accept at edge T drops op_ready in cycle T+1 and writes in T+1; done=1 from T+2.
- Flush:
  - flush in RUN blocks an accept in the same cycle.
  - Any write already registered still completes the next cycle.
  - The DONE transition is registered, so done=1 on the cycle after the flush cycle.
- start and flush together: flush wins in RUN; start wins in IDLE and DONE.
- Reset mid-session: a pending write is dropped (imem_we=0 the cycle after the reset edge), and all outputs return to their reset values.

## Configuration
- ENC_ADDI_EN:
  - Defined: kind 9 encodes ADDI (opcode 001000).
  - Undefined: kind 9 is illegal and handled as an illegal accept (err_illegal pulse, no write). The ADDI opcode constant and encode path are not compiled.

## Test plan
- Reset, start, then ADD rs=1 rt=2 rd=3 → imem_we one cycle later, imem_addr=0, imem_wdata=0x00221820, count=1.
- Back-to-back LW rs=4 rt=5 imm=0x0010, SW rs=4 rt=5 imm=0xFFFC, BEQ rs=1 rt=2 imm=3 → words 0x8C850010, 0xAC85FFFC, 0x10220003 at addrs 0,1,2 on consecutive cycles.
- DEPTH=4: five requests held valid → exactly 4 writes at addrs 0–3, op_ready low after the 4th accept, done=1, fifth request never accepted.
- op_kind=12 between two ADDs → err_illegal pulse, no write, second ADD written at addr 1, count=2.
- ADDI rs=0 rt=8 imm=0x0005 → with ENC_ADDI_EN: 0x20080005 written; without it: err_illegal pulse, no write.
- Flush with a write pending, then reset asserted during a later session → pending write completes, done=1; after reset, imem_we=0 and all outputs at reset values.
